// File: rtl/rgmii_rx_sink.sv
// RGMII/MII nibble receiver: strips preamble/SFD and emits byte frames on AXI-stream.
// Optional FCS check with RGMII_RX_SINK_FCS_CHECK_EN.
module rgmii_rx_sink #(
   parameter int DATA_WIDTH  = 4,
   parameter int COUNT_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [DATA_WIDTH-1:0]  rgmii_d,
   input  logic                   rgmii_ctl,
   input  logic                   rgmii_clk_en,
   input  logic                   rgmii_mii_sel,
   output logic [7:0]             m_axis_tdata,
   output logic                   m_axis_tvalid,
   output logic                   m_axis_tlast,
   output logic                   m_axis_tuser,
   output logic                   error_bad_sfd,
   output logic                   error_bad_frame,
   output logic [COUNT_WIDTH-1:0] good_frame_count,
   output logic [COUNT_WIDTH-1:0] bad_frame_count
);

   typedef enum logic [2:0] {
      SYNC,
      IDLE,
      PREAMBLE,
      DATA,
      DROP
   } state_t;

   state_t                    state;
   logic                      phase;
   logic [DATA_WIDTH-1:0]     lo_nib;
   logic [2*DATA_WIDTH-1:0]   rx_byte;
   logic [7:0]                hold_data;
   logic                      hold_full;
   logic                      frame_err;
   logic                      er;
   logic                      fcs_bad;
   logic                      end_err;

   assign rx_byte = {rgmii_d, lo_nib};
   // A byte only completes when DV was 1 at phase0, so ER reduces to ~ctl.
   assign er      = !rgmii_mii_sel && !rgmii_ctl;
   assign end_err = frame_err | fcs_bad;

`ifdef RGMII_RX_SINK_FCS_CHECK_EN
   logic [31:0] crc;
   logic [2:0]  crc_cnt;

   function automatic logic [31:0] crc_next(input logic [31:0] c,
                                            input logic [7:0]  b);
      logic [31:0] r;
      r = c ^ {24'd0, b};
      for (int i = 0; i < 8; i++)
         r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
      return r;
   endfunction

   assign fcs_bad = (crc != 32'hDEBB20E3) || (crc_cnt != 3'd4);
`else
   assign fcs_bad = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= SYNC;
         phase            <= 1'b0;
         lo_nib           <= '0;
         hold_data        <= '0;
         hold_full        <= 1'b0;
         frame_err        <= 1'b0;
         m_axis_tdata     <= '0;
         m_axis_tvalid    <= 1'b0;
         m_axis_tlast     <= 1'b0;
         m_axis_tuser     <= 1'b0;
         error_bad_sfd    <= 1'b0;
         error_bad_frame  <= 1'b0;
         good_frame_count <= '0;
         bad_frame_count  <= '0;
`ifdef RGMII_RX_SINK_FCS_CHECK_EN
         crc              <= '1;
         crc_cnt          <= '0;
`endif
      end else begin
         m_axis_tvalid   <= 1'b0;
         m_axis_tlast    <= 1'b0;
         error_bad_sfd   <= 1'b0;
         error_bad_frame <= 1'b0;
         if (rgmii_clk_en) begin
            unique case (state)
               SYNC: begin
                  if (!rgmii_ctl) state <= IDLE;
               end
               IDLE: begin
                  phase <= 1'b0;
                  if (rgmii_ctl) begin
                     lo_nib <= rgmii_d;
                     phase  <= 1'b1;
                     state  <= PREAMBLE;
                  end
               end
               PREAMBLE: begin
                  if (!phase) begin
                     if (!rgmii_ctl) begin
                        state <= IDLE;
                     end else begin
                        lo_nib <= rgmii_d;
                        phase  <= 1'b1;
                     end
                  end else begin
                     phase <= 1'b0;
                     if (rx_byte == 8'hD5) begin
                        state     <= DATA;
                        hold_full <= 1'b0;
                        frame_err <= 1'b0;
`ifdef RGMII_RX_SINK_FCS_CHECK_EN
                        crc       <= '1;
                        crc_cnt   <= '0;
`endif
                     end else if (rx_byte != 8'h55) begin
                        error_bad_sfd <= 1'b1;
                        state         <= DROP;
                     end
                  end
               end
               DATA: begin
                  if (!phase) begin
                     if (!rgmii_ctl) begin
                        state     <= IDLE;
                        hold_full <= 1'b0;
                        frame_err <= 1'b0;
                        if (hold_full) begin
                           m_axis_tvalid   <= 1'b1;
                           m_axis_tlast    <= 1'b1;
                           m_axis_tdata    <= hold_data;
                           m_axis_tuser    <= end_err;
                           error_bad_frame <= end_err;
                           if (end_err)
                              bad_frame_count <= bad_frame_count + 1'b1;
                           else
                              good_frame_count <= good_frame_count + 1'b1;
                        end
                     end else begin
                        lo_nib <= rgmii_d;
                        phase  <= 1'b1;
                     end
                  end else begin
                     phase     <= 1'b0;
                     hold_data <= rx_byte;
                     hold_full <= 1'b1;
                     frame_err <= frame_err | er;
`ifdef RGMII_RX_SINK_FCS_CHECK_EN
                     crc <= crc_next(crc, rx_byte);
                     if (crc_cnt != 3'd4) crc_cnt <= crc_cnt + 3'd1;
`endif
                     if (hold_full) begin
                        m_axis_tvalid <= 1'b1;
                        m_axis_tdata  <= hold_data;
                        m_axis_tuser  <= 1'b0;
                     end
                  end
               end
               DROP: begin
                  if (!rgmii_ctl) state <= IDLE;
               end
               default: state <= SYNC;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_rgmii_rx_sink.sv
// Randomised frame-level bench for rgmii_rx_sink with an in-bench
// behavioural model (expected beats with due cycles) and directed frames.
`timescale 1ns/1ps
module tb_rgmii_rx_sink;
   localparam int CW = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [3:0]    rgmii_d = '0;
   logic          rgmii_ctl = 1'b0;
   logic          rgmii_clk_en = 1'b0;
   logic          rgmii_mii_sel = 1'b0;
   logic [7:0]    m_axis_tdata;
   logic          m_axis_tvalid;
   logic          m_axis_tlast;
   logic          m_axis_tuser;
   logic          error_bad_sfd;
   logic          error_bad_frame;
   logic [CW-1:0] good_frame_count;
   logic [CW-1:0] bad_frame_count;

   rgmii_rx_sink #(.DATA_WIDTH(4), .COUNT_WIDTH(CW)) dut (
      .clk              (clk),
      .rst              (rst),
      .rgmii_d          (rgmii_d),
      .rgmii_ctl        (rgmii_ctl),
      .rgmii_clk_en     (rgmii_clk_en),
      .rgmii_mii_sel    (rgmii_mii_sel),
      .m_axis_tdata     (m_axis_tdata),
      .m_axis_tvalid    (m_axis_tvalid),
      .m_axis_tlast     (m_axis_tlast),
      .m_axis_tuser     (m_axis_tuser),
      .error_bad_sfd    (error_bad_sfd),
      .error_bad_frame  (error_bad_frame),
      .good_frame_count (good_frame_count),
      .bad_frame_count  (bad_frame_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] data;
      bit         last;
      bit         user;
      int         due;
   } beat_t;

   beat_t         exp_q[$];
   logic [7:0]    pre_q[$];
   logic [7:0]    dat_q[$];
   bit            er_q[$];
   int            checks = 0;
   int            errors = 0;
   int            cyc = 0;
   int            gap_min = 0;
   int            gap_max = 0;
   int            sfd_due = -1;
   logic [CW-1:0] mdl_good = '0;
   logic [CW-1:0] mdl_bad = '0;
   int            mdl_sfd = 0;
   int            mdl_ebf = 0;
   int            sfd_cnt = 0;
   int            ebf_cnt = 0;
   int            frame_beats = 0;
   int            last_len = 0;
   logic [7:0]    last_data = '0;
   bit            last_user = 1'b0;
   bit            en_q = 1'b0;
   bit            rst_q = 1'b1;
   logic [7:0]    prev_tdata = '0;
   logic [CW-1:0] prev_good = '0;
   logic [CW-1:0] prev_bad = '0;
   logic          prev_user = 1'b0;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
                  name, act, exp, cyc);
      end
   endtask

   always @(posedge clk) begin
      cyc   <= cyc + 1;
      en_q  <= rgmii_clk_en;
      rst_q <= rst;
   end

   always @(negedge clk) begin
      beat_t e;
      if (rst_q) begin
         frame_beats = 0;
      end else begin
         if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            e = exp_q.pop_front();
            chk("tvalid", m_axis_tvalid, 1);
            chk("tdata", m_axis_tdata, e.data);
            chk("tlast", m_axis_tlast, e.last);
            chk("bad_frame_pulse", error_bad_frame, e.last && e.user);
            if (e.last) begin
               chk("tuser", m_axis_tuser, e.user);
               chk("good_count", good_frame_count, mdl_good);
               chk("bad_count", bad_frame_count, mdl_bad);
            end
         end else begin
            chk("tvalid_quiet", m_axis_tvalid, 0);
            chk("tlast_quiet", m_axis_tlast, 0);
            chk("bad_frame_quiet", error_bad_frame, 0);
            if (!en_q) begin
               chk("hold_tdata", m_axis_tdata, prev_tdata);
               chk("hold_tuser", m_axis_tuser, prev_user);
               chk("hold_good", good_frame_count, prev_good);
               chk("hold_bad", bad_frame_count, prev_bad);
            end
         end
         if (sfd_due == cyc) chk("sfd_pulse", error_bad_sfd, 1);
         else chk("sfd_quiet", error_bad_sfd, 0);
         if (error_bad_sfd) sfd_cnt++;
         if (error_bad_frame) ebf_cnt++;
         if (m_axis_tvalid) begin
            frame_beats++;
            if (m_axis_tlast) begin
               last_len    = frame_beats;
               last_data   = m_axis_tdata;
               last_user   = m_axis_tuser;
               frame_beats = 0;
            end
         end
      end
      prev_tdata = m_axis_tdata;
      prev_user  = m_axis_tuser;
      prev_good  = good_frame_count;
      prev_bad   = bad_frame_count;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic samp(input logic [3:0] d, input logic c);
      int g;
      g = (gap_max > gap_min) ? $urandom_range(gap_max, gap_min) : gap_min;
      for (int i = 0; i < g; i++) begin
         rgmii_clk_en = 1'b0;
         rgmii_d      = 4'($urandom);
         rgmii_ctl    = 1'($urandom);
         tick();
      end
      rgmii_clk_en = 1'b1;
      rgmii_d      = d;
      rgmii_ctl    = c;
      tick();
      rgmii_clk_en = 1'b0;
   endtask

   task automatic push(input logic [7:0] d, input bit l, input bit u);
      beat_t b;
      b.data = d;
      b.last = l;
      b.user = u;
      b.due  = cyc;
      exp_q.push_back(b);
   endtask

   task automatic add_byte(input logic [7:0] b, input bit er);
      dat_q.push_back(b);
      er_q.push_back(er);
   endtask

   task automatic clear_frame();
      pre_q.delete();
      dat_q.delete();
      er_q.delete();
   endtask

`ifdef RGMII_RX_SINK_FCS_CHECK_EN
   function automatic logic [31:0] crc_upd(input logic [31:0] c,
                                           input logic [7:0]  b);
      logic [31:0] r;
      r = c;
      for (int k = 0; k < 8; k++) begin
         if (r[0] ^ b[k]) r = (r >> 1) ^ 32'hEDB88320;
         else r = r >> 1;
      end
      return r;
   endfunction

   task automatic append_fcs(input bit flip);
      logic [31:0] c;
      c = '1;
      foreach (dat_q[i]) c = crc_upd(c, dat_q[i]);
      c = ~c;
      for (int k = 0; k < 4; k++) add_byte(c[8*k +: 8], 1'b0);
      if (flip)
         dat_q[dat_q.size()-1] ^= 8'h01 << $urandom_range(7, 0);
   endtask
`endif

   // Drives pre_q then dat_q; abort_at >= 0 resets the DUT after that byte.
   task automatic send_frame(input bit mii, input int abort_at);
      bit   good;
      bit   dead;
      bit   err;
      bit   u;
      logic c1;
      int   n;
      good = 0;
      dead = 0;
      err  = 0;
      n    = dat_q.size();
      rgmii_mii_sel = mii;
      foreach (pre_q[i]) begin
         samp(pre_q[i][3:0], 1'b1);
         samp(pre_q[i][7:4], 1'b1);
         if (!good && !dead) begin
            if (pre_q[i] == 8'hD5) begin
               good = 1;
            end else if (pre_q[i] != 8'h55) begin
               dead = 1;
               mdl_sfd++;
               sfd_due = cyc;
            end
         end
      end
      foreach (dat_q[i]) begin
         samp(dat_q[i][3:0], 1'b1);
         if (dead) c1 = 1'b1;
         else if (mii) c1 = 1'($urandom);
         else c1 = !er_q[i];
         samp(dat_q[i][7:4], c1);
         if (good) begin
            if (!mii && er_q[i]) err = 1;
            if (i > 0) push(dat_q[i-1], 1'b0, 1'b0);
         end
         if (i == abort_at) begin
            rst = 1'b1;
            samp(4'h5, 1'b1);
            samp(4'h5, 1'b1);
            mdl_good = '0;
            mdl_bad  = '0;
            rst = 1'b0;
            return;
         end
      end
      samp(4'($urandom), 1'b0);
      if (good && n > 0) begin
         u = err;
`ifdef RGMII_RX_SINK_FCS_CHECK_EN
         begin
            logic [31:0] r;
            r = '1;
            foreach (dat_q[i]) r = crc_upd(r, dat_q[i]);
            if (n < 4 || r != 32'hDEBB20E3) u = 1;
         end
`endif
         if (u) begin
            mdl_bad++;
            mdl_ebf++;
         end else begin
            mdl_good++;
         end
         push(dat_q[n-1], 1'b1, u);
      end
      repeat ($urandom_range(3, 1)) samp(4'($urandom), 1'b0);
   endtask

   task automatic std_pre(input int np);
      repeat (np) pre_q.push_back(8'h55);
      pre_q.push_back(8'hD5);
   endtask

   initial begin
      #800000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1);
   end

   initial begin
      logic [7:0] b;
      int kind;
      repeat (3) tick();
      chk("rst_tdata", m_axis_tdata, 0);
      chk("rst_tvalid", m_axis_tvalid, 0);
      chk("rst_tlast", m_axis_tlast, 0);
      chk("rst_tuser", m_axis_tuser, 0);
      chk("rst_bad_sfd", error_bad_sfd, 0);
      chk("rst_bad_frame", error_bad_frame, 0);
      chk("rst_good", good_frame_count, 0);
      chk("rst_bad", bad_frame_count, 0);
      rst = 1'b0;
      samp(4'h0, 1'b0);

      clear_frame();
      std_pre(7);
      for (int i = 1; i <= 64; i++) add_byte(8'(i), 1'b0);
      send_frame(1'b0, -1);
      chk("t1_len", last_len, 64);
      chk("t1_last", last_data, 8'h40);
`ifndef RGMII_RX_SINK_FCS_CHECK_EN
      chk("t1_user", last_user, 0);
      chk("t1_good", good_frame_count, 1);
`endif

      er_q[9] = 1'b1;
      send_frame(1'b0, -1);
      chk("t2_len", last_len, 64);
      chk("t2_user", last_user, 1);
`ifndef RGMII_RX_SINK_FCS_CHECK_EN
      chk("t2_bad", bad_frame_count, 1);
      chk("t2_pulses", ebf_cnt, 1);
`else
      chk("t2_bad", bad_frame_count, 2);
      chk("t2_pulses", ebf_cnt, 2);
`endif

      clear_frame();
      pre_q = '{8'h55, 8'h55, 8'h5A};
      add_byte(8'h11, 1'b0);
      add_byte(8'h22, 1'b0);
      send_frame(1'b0, -1);
      chk("t3_sfd", sfd_cnt, 1);
      clear_frame();
      std_pre(3);
      add_byte(8'h10, 1'b0);
      add_byte(8'h20, 1'b0);
      add_byte(8'h30, 1'b0);
      send_frame(1'b0, -1);
      chk("t3_len", last_len, 3);
      chk("t3_last", last_data, 8'h30);

      clear_frame();
      std_pre(3);
      for (int i = 0; i < 8; i++) add_byte(8'hA1 + 8'(i), 1'b0);
      send_frame(1'b0, 4);
      repeat (4) samp(4'hD, 1'b1);
      samp(4'h0, 1'b0);
      chk("t4_cleared", good_frame_count, 0);
      clear_frame();
      std_pre(2);
      for (int i = 0; i < 8; i++) add_byte(8'hC0 + 8'(i), 1'b0);
      send_frame(1'b0, -1);
      chk("t4_len", last_len, 8);
      chk("t4_last", last_data, 8'hC7);
`ifndef RGMII_RX_SINK_FCS_CHECK_EN
      chk("t4_good", good_frame_count, 1);
      chk("t4_bad", bad_frame_count, 0);
`endif

      clear_frame();
      std_pre(7);
      add_byte(8'hAA, 1'b0);
      add_byte(8'hBB, 1'b0);
      gap_min = 2;
      gap_max = 2;
      send_frame(1'b1, -1);
      gap_min = 0;
      gap_max = 0;
      chk("t5_len", last_len, 2);
      chk("t5_last", last_data, 8'hBB);
`ifndef RGMII_RX_SINK_FCS_CHECK_EN
      chk("t5_user", last_user, 0);
`else
      clear_frame();
      std_pre(7);
      for (int i = 0; i < 60; i++) add_byte(8'($urandom), 1'b0);
      append_fcs(1'b0);
      send_frame(1'b0, -1);
      chk("t6_len", last_len, 64);
      chk("t6_user", last_user, 0);
      chk("t6_good", good_frame_count, 1);
      clear_frame();
      std_pre(7);
      for (int i = 0; i < 60; i++) add_byte(8'($urandom), 1'b0);
      append_fcs(1'b1);
      send_frame(1'b0, -1);
      chk("t7_user", last_user, 1);
      chk("t7_bad", bad_frame_count, 3);
`endif

      repeat (120) begin
         clear_frame();
         gap_min = 0;
         gap_max = $urandom_range(1, 0) ? 0 : 2;
         kind = $urandom_range(9, 0);
         repeat ($urandom_range(7, 0)) pre_q.push_back(8'h55);
         if (kind == 0) begin
            if (pre_q.size() == 0) pre_q.push_back(8'h55);
         end else if (kind == 1) begin
            do b = 8'($urandom); while (b == 8'h55 || b == 8'hD5);
            pre_q.push_back(b);
            repeat ($urandom_range(5, 0)) add_byte(8'($urandom), 1'b0);
         end else begin
            pre_q.push_back(8'hD5);
            repeat ($urandom_range(24, 0))
               add_byte(8'($urandom), $urandom_range(15, 0) == 0);
`ifdef RGMII_RX_SINK_FCS_CHECK_EN
            if ($urandom_range(1, 0) == 1)
               append_fcs($urandom_range(3, 0) == 0);
`endif
         end
         send_frame(1'($urandom), -1);
      end
      gap_min = 0;
      gap_max = 0;
      repeat (5) samp(4'h0, 1'b0);
      chk("end_good", good_frame_count, mdl_good);
      chk("end_bad", bad_frame_count, mdl_bad);
      chk("end_sfd", sfd_cnt, mdl_sfd);
      chk("end_pulses", ebf_cnt, mdl_ebf);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
